// File: rtl/decap_ctrl_pkg.sv
// decap_ctrl_pkg: shared state encoding and constants for the decapsulation control FSM
package decap_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, INIT, A_ADDR, A_WAIT, A_CAP, A_WR,
    B_ADDR, B_WAIT, B_CAP, B_WR, S_LD, S_WR, DONE
  } state_e;
  localparam logic [10:0] S_DEG_ADDR = 11'd2047;
  // bit k-1 is select line Rk; hold keeps every datapath register unchanged
  localparam logic [11:0] HOLD_SEL = 12'h13F;
  localparam int DEF_P = 757;
  localparam int DEF_RD_LAT = 1;
endpackage

// File: rtl/decap_wait_cnt.sv
// decap_wait_cnt: read-latency down-counter flagging the first and last wait cycle
module decap_wait_cnt
  import decap_ctrl_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic first_o,
  output logic last_o
);
  localparam int W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [W-1:0] INIT_CNT = W'(RD_LAT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == '0;
  assign first_o = cnt_q == INIT_CNT;
  assign cnt_d = load_i ? INIT_CNT : (dec_i && !last_o) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/decap_ctrl.sv
// decap_ctrl: sequences the reduction pass, mod-3 pass and degree write of the decap datapath
module decap_ctrl
  import decap_ctrl_pkg::*;
#(
  parameter int P = DEF_P,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] i,
  input  logic [10:0] j,
  output logic        busy,
  output logic        done,
  output logic        we_e,
  output logic        we_S,
  output logic        R1,
  output logic        R2,
  output logic        R3,
  output logic        R4,
  output logic        R5,
  output logic        R6,
  output logic        R7,
  output logic        R8,
  output logic        R9,
  output logic        R10,
  output logic        R11,
  output logic        R12
);
  localparam logic [10:0] P_W = 11'(P);
  state_e state_q;
  logic wait_first, wait_last;
  logic [11:0] sel;
  decap_wait_cnt #(.RD_LAT(RD_LAT)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == A_ADDR || state_q == B_ADDR),
    .dec_i  (state_q == A_WAIT || state_q == B_WAIT),
    .first_o(wait_first),
    .last_o (wait_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else
      case (state_q)
        IDLE:    if (start) state_q <= INIT;
        INIT:    state_q <= A_ADDR;
        A_ADDR:  state_q <= A_WAIT;
        A_WAIT:  if (wait_last) state_q <= A_CAP;
        A_CAP:   state_q <= A_WR;
        A_WR:    state_q <= i == P_W ? B_ADDR : A_ADDR;
        B_ADDR:  state_q <= B_WAIT;
        B_WAIT:  if (wait_last) state_q <= B_CAP;
        B_CAP:   state_q <= B_WR;
        B_WR:    state_q <= j == P_W ? S_LD : B_ADDR;
        S_LD:    state_q <= S_WR;
        S_WR:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
  // counters advance in ADDR, so the old value is the element address k
  always_comb begin
    sel = HOLD_SEL;
    we_e = 1'b0;
    we_S = 1'b0;
    case (state_q)
      INIT:    begin sel[5] = 1'b0; sel[8] = 1'b0; end
      A_ADDR:  begin sel[5] = 1'b0; sel[6] = 1'b1; sel[3] = 1'b0; end
      A_WAIT:  sel[4] = !wait_first;
      A_CAP:   sel[2] = 1'b0;
      A_WR:    we_e = 1'b1;
      B_ADDR:  begin sel[8] = 1'b0; sel[9] = 1'b1; sel[10] = 1'b1; end
      B_WAIT:  sel[11] = wait_first;
      B_CAP:   sel[7] = 1'b1;
      B_WR:    we_e = 1'b1;
      S_LD:    begin sel[0] = 1'b0; sel[1] = 1'b0; end
      S_WR:    we_S = 1'b1;
      default: ;
    endcase
  end
  assign {R12, R11, R10, R9, R8, R7, R6, R5, R4, R3, R2, R1} = sel;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_decap_ctrl.sv
// tb_decap_ctrl: three controller configurations, each driving a behavioural datapath, checked by a write scoreboard
module tb_decap_ctrl;
  localparam int PN [3] = '{4, 2, 757};
  localparam int LT [3] = '{1, 3, 1};
  localparam logic [15:0] DEGM = 16'h0ABC;
  localparam logic [11:0] HOLD = 12'h13F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st [3] = '{default: 1'b0};
  wire busy [3], done [3], we_e [3], we_s [3];
  wire [11:0] r [3];
  logic [10:0] ci [3] = '{default: '0};
  logic [10:0] cj [3] = '{default: '0};
  logic [10:0] ra [3] = '{default: '0};
  logic [10:0] wa [3] = '{default: '0};
  logic [10:0] sa [3] = '{default: '0};
  logic [15:0] ed [3] = '{default: '0};
  logic [15:0] sd [3] = '{default: '0};
  int total = 0, bad = 0, cyc = 0;
  int wec [3] = '{default: 0};
  int dcnt [3] = '{default: 0};
  int rdc [3] = '{default: 0};
  bit sb_on = 1'b0;
  logic [29:0] sb [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    decap_ctrl #(.P(PN[g]), .RD_LAT(LT[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .i(ci[g]), .j(cj[g]),
      .busy(busy[g]), .done(done[g]), .we_e(we_e[g]), .we_S(we_s[g]),
      .R1(r[g][0]), .R2(r[g][1]), .R3(r[g][2]), .R4(r[g][3]), .R5(r[g][4]), .R6(r[g][5]),
      .R7(r[g][6]), .R8(r[g][7]), .R9(r[g][8]), .R10(r[g][9]), .R11(r[g][10]), .R12(r[g][11])
    );
  end

  // datapath model: counters, address registers and data registers steered by R1..R12
  always @(posedge clk)
    for (int n = 0; n < 3; n++) begin
      ci[n] <= r[n][5] ? ci[n] : r[n][6] ? ci[n] + 11'd1 : '0;
      cj[n] <= r[n][8] ? cj[n] : r[n][9] ? cj[n] + 11'd1 : '0;
      ra[n] <= r[n][10] ? cj[n] : r[n][3] ? ra[n] : ci[n];
      wa[n] <= r[n][11] ? cj[n] - 11'd1 : r[n][4] ? wa[n] : ci[n] - 11'd1;
      ed[n] <= r[n][7] ? 16'h200 + 16'(ra[n]) : r[n][2] ? ed[n] : 16'h100 + 16'(ra[n]);
      sa[n] <= r[n][1] ? sa[n] : 11'd2047;
      sd[n] <= r[n][0] ? sd[n] : DEGM;
    end

  // output monitor: scoreboard pops on writes, capture latency and pass ordering
  initial begin : mon
    logic [29:0] got, want;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n)
        for (int n = 0; n < 3; n++) begin
          if (we_e[n]) wec[n]++;
          if (done[n]) dcnt[n]++;
          if (sb_on && (we_e[n] || we_s[n])) begin
            got = we_s[n] ? {1'b1, 2'(n), sa[n], sd[n]} : {1'b0, 2'(n), wa[n], ed[n]};
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL write_unexpected inst=%0d got=%h want=none", n, got);
            end else begin
              want = sb.pop_front();
              if (got !== want) begin
                bad++;
                $display("FAIL write_data inst=%0d got=%h want=%h", n, got, want);
              end
            end
          end
          if (!r[n][3]) rdc[n] = cyc;
          if (!r[n][2]) begin
            total++;
            if (cyc - rdc[n] !== 1 + LT[n]) begin
              bad++;
              $display("FAIL cap_latency inst=%0d got=%0d want=%0d", n, cyc - rdc[n], 1 + LT[n]);
            end
          end
          if (r[n][7] || r[n][10] || r[n][11]) begin
            total++;
            if (wec[n] < PN[n]) begin
              bad++;
              $display("FAIL pass_order inst=%0d a_writes=%0d want>=%0d", n, wec[n], PN[n]);
            end
          end
        end
    end
  end

  task automatic push_run(input int n);
    for (int k = 0; k < PN[n]; k++) sb.push_back({1'b0, 2'(n), 11'(k), 16'h100 + 16'(k)});
    for (int k = 0; k < PN[n]; k++) sb.push_back({1'b0, 2'(n), 11'(k), 16'h200 + 16'(k)});
    sb.push_back({1'b1, 2'(n), 11'd2047, DEGM});
  endtask

  task automatic run(input int n, input int hold, input int exp_edge, input bit start_in_done);
    int edges;
    push_run(n);
    wec[n] = 0;
    dcnt[n] = 0;
    @(negedge clk);
    st[n] = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges >= hold) st[n] = 1'b0;
    end while (!done[n] && edges < 10000);
    total++;
    if (edges !== exp_edge) begin
      bad++;
      $display("FAIL done_edge inst=%0d got=%0d want=%0d", n, edges, exp_edge);
    end
    if (start_in_done) begin
      st[n] = 1'b1;
      @(negedge clk);
      st[n] = 1'b0;
    end
    repeat (12) @(negedge clk);
    total += 4;
    if (dcnt[n] !== 1) begin
      bad++;
      $display("FAIL done_pulses inst=%0d got=%0d want=1", n, dcnt[n]);
    end
    if (wec[n] !== 2 * PN[n]) begin
      bad++;
      $display("FAIL we_e_count inst=%0d got=%0d want=%0d", n, wec[n], 2 * PN[n]);
    end
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL writes_missing inst=%0d got=%0d want=0", n, sb.size());
      sb.delete();
    end
    if (busy[n] !== 1'b0) begin
      bad++;
      $display("FAIL idle_after inst=%0d got=%b want=0", n, busy[n]);
    end
  endtask

  task automatic test_reset();
    int c;
    bit any_we;
    #3;
    for (int n = 0; n < 3; n++) begin
      total++;
      if ({busy[n], done[n], we_e[n], we_s[n], r[n]} !== {4'b0000, HOLD}) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d got=%b want=%b", n,
                 {busy[n], done[n], we_e[n], we_s[n], r[n]}, {4'b0000, HOLD});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    c = 0;
    while (ci[2] !== 11'd37 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (ci[2] !== 11'd37) begin
      bad++;
      $display("FAIL reach_i37 got=%0d want=37", ci[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy[2], done[2], we_e[2], we_s[2], r[2]} !== {4'b0000, HOLD}) begin
      bad++;
      $display("FAIL reset_midrun got=%b want=%b", {busy[2], done[2], we_e[2], we_s[2], r[2]}, {4'b0000, HOLD});
    end
    any_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_we |= we_e[2] | we_s[2];
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      any_we |= we_e[2] | we_s[2] | busy[2];
    end
    total++;
    if (any_we !== 1'b0) begin
      bad++;
      $display("FAIL write_after_reset got=%b want=0", any_we);
    end
  endtask

  task automatic test_full_p4();
    run(0, 1, 36, 1'b0);
  endtask

  task automatic test_handshake();
    run(0, 10, 36, 1'b1);
  endtask

  task automatic test_lat3();
    run(1, 1, 28, 1'b0);
  endtask

  task automatic test_default();
    run(2, 1, 6060, 1'b0);
  endtask

  initial begin
    test_reset();
    sb_on = 1'b1;
    test_full_p4();
    test_handshake();
    test_lat3();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
